// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-address decode helper.
// Pure declarations: no latency, no flow control.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[a] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Read/write port bundle of the 2R1W register file (decode stage reads, writeback writes).
// Reads are 0-cycle combinational, the write lands on the next clock edge; no backpressure.
interface reg_file_2r1w_if;
  import regfile_pkg::*;

  logic [ADDR_W-1:0] ard1;
  logic [ADDR_W-1:0] ard2;
  logic [ADDR_W-1:0] awr;
  logic [DATA_W-1:0] din;
  logic              wren;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;

  modport master (output ard1, ard2, awr, din, wren, input dout1, dout2);
  modport slave  (input ard1, ard2, awr, din, wren, output dout1, dout2);
endinterface

// File: rtl/mux32to1.sv
// 32-way read selector feeding one register-file read port.
// Purely combinational, 0-cycle latency; no flow control.
module mux32to1
  import regfile_pkg::*;
(
  input  logic [DATA_W-1:0] din [NUM_REGS],
  input  logic [ADDR_W-1:0] sel,
  output logic [DATA_W-1:0] dout
);

  assign dout = din[sel];

endmodule

// File: rtl/reg32_we.sv
// One register with synchronous load enable and asynchronous active-low clear.
// Load takes effect at the rising edge; the register never stalls.
module reg32_we #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational reads, one write at the clock edge; optional write-through
// forwarding under REGFILE_BYPASS_EN. Read latency 0 cycles, write visible next cycle; never stalls.
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_file_2r1w_if.slave        rf
);

  logic [NUM_REGS-1:0] we_vec;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;

  assign we_vec = addr_onehot(rf.awr) & {NUM_REGS{rf.wren}};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0 && ZERO_REG) begin : g_zero
      // Hardwired R0: its decoded enable is intentionally left without a load.
      logic unused_we0;
      assign unused_we0 = we_vec[0];
      assign regs[i]    = '0;
    end else begin : g_store
      reg32_we #(.W(DATA_W)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (we_vec[i]),
        .d     (rf.din),
        .q     (regs[i])
      );
    end
  end

  mux32to1 u_mux1 (.din(regs), .sel(rf.ard1), .dout(rd1));
  mux32to1 u_mux2 (.din(regs), .sel(rf.ard2), .dout(rd2));

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  logic hit1;
  logic hit2;

  // Forwarding is gated by reset so the ports read 0 while the array is held clear.
  assign wr_live  = rst_n && rf.wren && !(ZERO_REG && (rf.awr == REG_ZERO));
  assign hit1     = wr_live && (rf.awr == rf.ard1);
  assign hit2     = wr_live && (rf.awr == rf.ard2);
  assign rf.dout1 = hit1 ? rf.din : rd1;
  assign rf.dout2 = hit2 ? rf.din : rd2;
`else
  assign rf.dout1 = rd1;
  assign rf.dout2 = rd2;
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: vector table plus hand sequences, expected reads queued and popped on check.
module tb_reg_file_2r1w;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_file_2r1w_if bus ();

  reg_file_2r1w dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       tag;
  } exp_t;

  typedef struct {
    logic        wren;
    logic [4:0]  awr;
    logic [31:0] din;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  exp_t        sb_q [$];
  vec_t        vecs [8];
  logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Pop the oldest queued expectation and compare it with both read ports.
  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected >=1");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_dout1"}, bus.dout1, e.e1);
      chk({e.tag, "_dout2"}, bus.dout2, e.e2);
    end
  endtask

  task automatic read_chk(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] e1, input logic [31:0] e2, input string tag);
    exp_t e;
    bus.ard1 = a1;
    bus.ard2 = a2;
    e.e1 = e1;
    e.e2 = e2;
    e.tag = tag;
    sb_q.push_back(e);
    #1;
    compare_out();
  endtask

  // Step past the next rising edge to a point safely away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wren = 1'b1;
    bus.awr  = a;
    bus.din  = d;
    tick();
    bus.wren = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.wren  = 1'b0;
    bus.awr   = '0;
    bus.din   = '0;
    bus.ard1  = '0;
    bus.ard2  = '0;

    vecs[0] = '{1'b1, 5'd10, 32'h0000_00AA, 5'd11, 5'd0,  32'h0,         32'h0};
    vecs[1] = '{1'b1, 5'd11, 32'h0000_00BB, 5'd10, 5'd10, 32'h0000_00AA, 32'h0000_00AA};
    vecs[2] = '{1'b0, 5'd10, 32'hFFFF_FFFF, 5'd11, 5'd10, 32'h0000_00BB, 32'h0000_00AA};
    vecs[3] = '{1'b1, 5'd31, 32'h8000_0001, 5'd10, 5'd11, 32'h0000_00AA, 32'h0000_00BB};
    vecs[4] = '{1'b1, 5'd0,  32'h1234_0000, 5'd31, 5'd0,  32'h8000_0001, 32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd31, 32'h0,         32'h8000_0001};
    vecs[6] = '{1'b1, 5'd10, 32'h5555_5555, 5'd11, 5'd31, 32'h0000_00BB, 32'h8000_0001};
    vecs[7] = '{1'b0, 5'd2,  32'h0,         5'd10, 5'd1,  32'h5555_5555, 32'h0};

    #2;
    read_chk(5'd0, 5'd17, 32'h0, 32'h0, "reset_init");
    rst_n = 1'b1;
    tick();

    // Write every register, then sweep both ports in opposite directions.
    model[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      model[i] = 32'h1000_0000 + i;
      wr(5'(i), model[i]);
    end
    for (int i = 0; i < 32; i++)
      read_chk(5'(i), 5'(31 - i), model[i], model[31 - i], $sformatf("sweep%0d", i));

    // R0 write is dropped, including any same-cycle forwarding.
    bus.wren = 1'b1;
    bus.awr  = 5'd0;
    bus.din  = 32'hFFFF_FFFF;
    read_chk(5'd0, 5'd1, 32'h0, 32'h1000_0001, "r0_pre");
    tick();
    bus.wren = 1'b0;
    read_chk(5'd0, 5'd0, 32'h0, 32'h0, "r0_post");

    // Read during write on reg7.
    wr(5'd7, 32'hA5A5_A5A5);
    bus.wren = 1'b1;
    bus.awr  = 5'd7;
    bus.din  = 32'h1234_5678;
    read_chk(5'd7, 5'd6, BYPASS ? 32'h1234_5678 : 32'hA5A5_A5A5, 32'h1000_0006, "rdw_pre");
    tick();
    bus.wren = 1'b0;
    read_chk(5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, "rdw_post");

    // Disabled write with live address and data must not disturb reg9.
    wr(5'd9, 32'h0000_0009);
    bus.wren = 1'b0;
    bus.awr  = 5'd9;
    bus.din  = 32'hCAFE_0000;
    for (int c = 0; c < 4; c++) begin
      read_chk(5'd9, 5'd9, 32'h0000_0009, 32'h0000_0009, $sformatf("wren0_c%0d", c));
      tick();
    end

    // Asynchronous reset lands mid-cycle, with no clock edge in between.
    wr(5'd5, 32'hDEAD_BEEF);
    read_chk(5'd5, 5'd7, 32'hDEAD_BEEF, 32'h1234_5678, "rst_before");
    rst_n = 1'b0;
    read_chk(5'd5, 5'd7, 32'h0, 32'h0, "rst_immediate");
    for (int i = 0; i < 32; i++)
      read_chk(5'(i), 5'(31 - i), 32'h0, 32'h0, $sformatf("rst_all%0d", i));
    #3;
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      bus.wren = vecs[v].wren;
      bus.awr  = vecs[v].awr;
      bus.din  = vecs[v].din;
      read_chk(vecs[v].ard1, vecs[v].ard2, vecs[v].e1, vecs[v].e2, $sformatf("vec%0d", v));
      tick();
    end
    bus.wren = 1'b0;

    // Reset held across a write edge wins; the following write still works.
    bus.wren = 1'b1;
    bus.awr  = 5'd3;
    bus.din  = 32'h3333_3333;
    bus.ard1 = 5'd3;
    #1;
    rst_n = 1'b0;
    read_chk(5'd3, 5'd3, 32'h0, 32'h0, "rstwr_low");
    tick();
    #1;
    bus.wren = 1'b0;
    rst_n    = 1'b1;
    tick();
    read_chk(5'd3, 5'd10, 32'h0, 32'h0, "rstwr_after");
    wr(5'd3, 32'h3C3C_3C3C);
    read_chk(5'd3, 5'd3, 32'h3C3C_3C3C, 32'h3C3C_3C3C, "rstwr_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
